// File: rtl/ysyx_25060170_retire_queue.sv
// Retire-record FIFO between writeback and commit/trace, with EBREAK halt.
// Optional perf counters: define YSYX_25060170_RETIRE_PERF_EN.
module ysyx_25060170_retire_queue #(
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned PTR_W       = $clog2(DEPTH),
    parameter logic [31:0] EBREAK_INST = 32'h00100073
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wb_valid,
    input  logic [31:0]      wb_pc,
    input  logic [31:0]      wb_inst,
    output logic             wb_ready,
    output logic             cm_valid,
    output logic [31:0]      cm_pc,
    output logic [31:0]      cm_inst,
    input  logic             cm_ready,
    output logic [PTR_W:0]   occupancy,
    output logic             halted
`ifdef YSYX_25060170_RETIRE_PERF_EN
    ,
    output logic [63:0]      perf_cycle,
    output logic [63:0]      perf_instret
`endif
);

    logic [31:0]    pc_mem_q   [DEPTH];
    logic [31:0]    inst_mem_q [DEPTH];

    logic [PTR_W:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0] rd_ptr_q, rd_ptr_d;
    logic           ebreak_seen_q, ebreak_seen_d;
    logic           halted_q, halted_d;

    logic [PTR_W-1:0] wr_idx;
    logic [PTR_W-1:0] rd_idx;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic [31:0]      head_pc;
    logic [31:0]      head_inst;

    assign wr_idx = wr_ptr_q[PTR_W-1:0];
    assign rd_idx = rd_ptr_q[PTR_W-1:0];

    assign full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) && (wr_idx == rd_idx);
    assign empty = (wr_ptr_q == rd_ptr_q);

    // Ready/valid come only from registered state: no comb handshake loops.
    assign wb_ready = ~full & ~ebreak_seen_q;
    assign cm_valid = ~empty;

    assign push = wb_valid & wb_ready;
    assign pop  = cm_valid & cm_ready;

    assign head_pc   = pc_mem_q[rd_idx];
    assign head_inst = inst_mem_q[rd_idx];

    // Zero when empty so stale or X storage never reaches the trace hook.
    assign cm_pc   = empty ? 32'h0 : head_pc;
    assign cm_inst = empty ? 32'h0 : head_inst;

    assign occupancy = wr_ptr_q - rd_ptr_q;
    assign halted    = halted_q;

    always_comb begin
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        ebreak_seen_d = ebreak_seen_q;
        halted_d      = halted_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
            if (wb_inst == EBREAK_INST) begin
                ebreak_seen_d = 1'b1;
            end
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            if (head_inst == EBREAK_INST) begin
                halted_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            ebreak_seen_q <= 1'b0;
            halted_q      <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            ebreak_seen_q <= ebreak_seen_d;
            halted_q      <= halted_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem_q[wr_idx]   <= wb_pc;
            inst_mem_q[wr_idx] <= wb_inst;
        end
    end

`ifdef YSYX_25060170_RETIRE_PERF_EN
    logic [63:0] perf_cycle_q, perf_cycle_d;
    logic [63:0] perf_instret_q, perf_instret_d;

    always_comb begin
        perf_cycle_d   = perf_cycle_q;
        perf_instret_d = perf_instret_q;
        if (!halted_q) begin
            perf_cycle_d = perf_cycle_q + 64'd1;
            if (pop) begin
                perf_instret_d = perf_instret_q + 64'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_cycle_q   <= '0;
            perf_instret_q <= '0;
        end else begin
            perf_cycle_q   <= perf_cycle_d;
            perf_instret_q <= perf_instret_d;
        end
    end

    assign perf_cycle   = perf_cycle_q;
    assign perf_instret = perf_instret_q;
`endif

endmodule

// File: tb/tb_ysyx_25060170_retire_queue.sv
// Bench for ysyx_25060170_retire_queue: vector table, corner sequences,
// and random traffic against a queue-based reference model.
module tb_ysyx_25060170_retire_queue;

    localparam int unsigned DEPTH = 4;
    localparam logic [31:0] EBRK  = 32'h00100073;
    localparam logic [31:0] NOP   = 32'h00000013;

    logic        clk;
    logic        rst;
    logic        wb_valid;
    logic [31:0] wb_pc;
    logic [31:0] wb_inst;
    logic        wb_ready;
    logic        cm_valid;
    logic [31:0] cm_pc;
    logic [31:0] cm_inst;
    logic        cm_ready;
    logic [2:0]  occupancy;
    logic        halted;
`ifdef YSYX_25060170_RETIRE_PERF_EN
    logic [63:0] perf_cycle;
    logic [63:0] perf_instret;
`endif

    ysyx_25060170_retire_queue #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .wb_valid  (wb_valid),
        .wb_pc     (wb_pc),
        .wb_inst   (wb_inst),
        .wb_ready  (wb_ready),
        .cm_valid  (cm_valid),
        .cm_pc     (cm_pc),
        .cm_inst   (cm_inst),
        .cm_ready  (cm_ready),
        .occupancy (occupancy),
        .halted    (halted)
`ifdef YSYX_25060170_RETIRE_PERF_EN
        ,
        .perf_cycle   (perf_cycle),
        .perf_instret (perf_instret)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input logic wv, input logic [31:0] pc,
                       input logic [31:0] inst, input logic cr);
        wb_valid = wv;
        wb_pc    = pc;
        wb_inst  = inst;
        cm_ready = cr;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        wv;
        logic [31:0] pc;
        logic [31:0] inst;
        logic        cr;
        logic        e_cv;
        logic [31:0] e_pc;
        logic [2:0]  e_occ;
        logic        e_rdy;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic wv, logic [31:0] pc, logic cr,
                                logic cv, logic [31:0] epc,
                                logic [2:0] occ, logic rdy);
        vec_t v;
        v.wv = wv; v.pc = pc; v.inst = 32'h00000413; v.cr = cr;
        v.e_cv = cv; v.e_pc = epc; v.e_occ = occ; v.e_rdy = rdy;
        return v;
    endfunction

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } rec_t;

    rec_t mq[$];
    bit   m_ebs;
    bit   m_halt;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] prev;
        rst = 1'b0; wb_valid = 1'b0; wb_pc = '0; wb_inst = '0;
        cm_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_cv",   cm_valid,  0);
        chk("rst_occ",  occupancy, 0);
        chk("rst_pc",   cm_pc,     0);
        chk("rst_inst", cm_inst,   0);
        chk("rst_halt", halted,    0);
        chk("rst_rdy",  wb_ready,  1);
        @(negedge clk);
        rst = 1'b1;

        // Single push, fill, blocked 5th push, drain in order.
        tbl.push_back(mk(1, 32'h80000000, 0, 1, 32'h80000000, 1, 1));
        tbl.push_back(mk(1, 32'h80000004, 0, 1, 32'h80000000, 2, 1));
        tbl.push_back(mk(1, 32'h80000008, 0, 1, 32'h80000000, 3, 1));
        tbl.push_back(mk(1, 32'h8000000C, 0, 1, 32'h80000000, 4, 0));
        tbl.push_back(mk(1, 32'h80000010, 0, 1, 32'h80000000, 4, 0));
        tbl.push_back(mk(0, 32'h0,        1, 1, 32'h80000004, 3, 1));
        tbl.push_back(mk(0, 32'h0,        1, 1, 32'h80000008, 2, 1));
        tbl.push_back(mk(0, 32'h0,        1, 1, 32'h8000000C, 1, 1));
        tbl.push_back(mk(0, 32'h0,        1, 0, 32'h0,        0, 1));
        tbl.push_back(mk(0, 32'h0,        1, 0, 32'h0,        0, 1));
        tbl.push_back(mk(1, 32'h800000A0, 0, 1, 32'h800000A0, 1, 1));

        foreach (tbl[i]) begin
            cyc(tbl[i].wv, tbl[i].pc, tbl[i].inst, tbl[i].cr);
            chk($sformatf("vec%0d_cv", i),  cm_valid,  tbl[i].e_cv);
            chk($sformatf("vec%0d_pc", i),  cm_pc,     tbl[i].e_pc);
            chk($sformatf("vec%0d_occ", i), occupancy, tbl[i].e_occ);
            chk($sformatf("vec%0d_rdy", i), wb_ready,  tbl[i].e_rdy);
        end

        // Simultaneous push/pop at occupancy 1 across pointer wrap.
        prev = 32'h800000A0;
        for (int i = 0; i < 10; i++) begin
            logic [31:0] npc;
            npc = 32'h800000B0 + 32'(4 * i);
            wb_valid = 1; wb_pc = npc; wb_inst = NOP; cm_ready = 1;
            #1;
            chk($sformatf("wrap%0d_head", i), cm_pc, prev);
            @(posedge clk);
            #1;
            chk($sformatf("wrap%0d_occ", i), occupancy, 1);
            chk($sformatf("wrap%0d_pc", i),  cm_pc,     npc);
            prev = npc;
        end

        // EBREAK blocks further pushes; halt follows its pop.
        cyc(0, 0, 0, 1);
        chk("eb_empty", occupancy, 0);
        cyc(1, 32'h800000C0, NOP, 0);
        chk("eb_rdy1", wb_ready, 1);
        cyc(1, 32'h800000C4, EBRK, 0);
        chk("eb_occ2", occupancy, 2);
        chk("eb_rdy0", wb_ready, 0);
        cyc(1, 32'h800000C8, NOP, 0);
        chk("eb_block", occupancy, 2);
        cyc(0, 0, 0, 1);
        chk("eb_head",  cm_inst, EBRK);
        chk("eb_nohalt", halted, 0);
        cyc(0, 0, 0, 1);
        chk("eb_halt", halted, 1);
        chk("eb_cv0",  cm_valid, 0);
        cyc(0, 0, 0, 0);
        chk("eb_sticky", halted, 1);

        // Async reset while halted, then mid-fill.
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("ar_halt0", halted, 0);
        chk("ar_rdy", wb_ready, 1);
        #1 rst = 1'b1;
        cyc(1, 32'h1000, NOP, 0);
        cyc(1, 32'h1004, NOP, 0);
        cyc(1, 32'h1008, NOP, 0);
        chk("ar_occ3", occupancy, 3);
        wb_valid = 0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("ar_occ0", occupancy, 0);
        chk("ar_cv0",  cm_valid, 0);
        chk("ar_pc0",  cm_pc, 0);
        #1 rst = 1'b1;

        // Random traffic against a queue model.
        mq.delete(); m_ebs = 0; m_halt = 0;
        cyc(0, 0, 0, 0);
        for (int c = 0; c < 3000; c++) begin
            logic        wv, cr;
            logic [31:0] pc, inst;
            bit          do_push, do_pop;
            chk("rnd_cv",   cm_valid, mq.size() > 0);
            chk("rnd_occ",  occupancy, mq.size());
            chk("rnd_rdy",  wb_ready, (mq.size() < DEPTH) && !m_ebs);
            chk("rnd_halt", halted, m_halt);
            chk("rnd_pc",   cm_pc,   mq.size() > 0 ? mq[0].pc   : 32'h0);
            chk("rnd_inst", cm_inst, mq.size() > 0 ? mq[0].inst : 32'h0);
            if (m_halt && mq.size() == 0 && $urandom_range(0, 3) == 0) begin
                rst = 1'b0;
                #1 rst = 1'b1;
                mq.delete(); m_ebs = 0; m_halt = 0;
            end
            wv   = $urandom_range(0, 3) != 0;
            cr   = $urandom_range(0, 2) != 0;
            pc   = $urandom;
            inst = ($urandom_range(0, 19) == 0) ? EBRK : $urandom;
            do_push = wv && (mq.size() < DEPTH) && !m_ebs;
            do_pop  = cr && (mq.size() > 0);
            cyc(wv, pc, inst, cr);
            if (do_pop) begin
                if (mq[0].inst == EBRK) m_halt = 1;
                void'(mq.pop_front());
            end
            if (do_push) begin
                mq.push_back('{pc: pc, inst: inst});
                if (inst == EBRK) m_ebs = 1;
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ysyx_25060170_retire_queue.md
Name: ysyx_25060170_retire_queue

Overview:
- Buffers retired-instruction records (pc, inst) from the writeback stage and presents them one per cycle to the commit/trace stage downstream (DPI-C commit hook, difftest).
- Decouples writeback timing from commit reporting, so load/store waits and ID stalls never drop or duplicate a retire record.
- Detects the EBREAK trap in retire order and raises a sticky halt once that instruction has been reported.

Parameters:
- DEPTH, 4, number of queue entries; power of 2, minimum 2.
- PTR_W, $clog2(DEPTH), index width. Read/write pointers are PTR_W+1 bits wide, and the extra MSB is the wrap bit.
- EBREAK_INST, 32'h00100073, encoding treated as the halt trap.

Ports:
- clk, input, 1, system clock; all state updates on the rising edge.
- rst, input, 1, asynchronous, active-low reset.
- wb_valid, input, 1, writeback presents a retired instruction this cycle.
- wb_pc, input, 32, PC of the retired instruction.
- wb_inst, input, 32, encoding of the retired instruction.
- wb_ready, output, 1, queue accepts the record; push happens when wb_valid & wb_ready.
- cm_valid, output, 1, head record available to commit stage.
- cm_pc, output, 32, head record PC.
- cm_inst, output, 32, head record instruction.
- cm_ready, input, 1, commit stage consumes head; pop happens when cm_valid & cm_ready.
- occupancy, output, PTR_W+1, current entry count, 0..DEPTH.
- halted, output, 1, sticky; the EBREAK record has been popped.

Behaviour:
- Reset (rst low, asynchronous):
  - Pointers cleared.
  - occupancy=0, cm_valid=0, halted=0, internal ebreak_seen=0.
  - cm_pc=0 and cm_inst=0.
  - Entry storage need not be cleared.
  - Reset asserted mid-operation discards all queued records immediately; there is no partial drain.
- Full and empty:
  - full = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) && (low bits equal).
  - empty = (wr_ptr == rd_ptr).
- Ready and valid:
  - wb_ready = ~full & ~ebreak_seen. It is combinational from registered state only and must not depend on wb_valid.
  - cm_valid = ~empty.
- Head outputs:
  - cm_pc and cm_inst are show-ahead: the entry at rd_ptr, driven combinationally from storage.
  - They read 0 whenever empty, so no X leaks to DPI.
- Latency: a record pushed in cycle N appears on cm_* in cycle N+1 when the queue was empty. There is no same-cycle bypass.
- Push and pop in the same cycle:
  - Both take effect and occupancy is unchanged.
  - This is legal at any occupancy 1..DEPTH-1.
  - At full, push is blocked by wb_ready=0 even if a pop occurs that cycle.
- Pointer arithmetic: wrap-around is natural modulo 2^(PTR_W+1); occupancy = wr_ptr - rd_ptr.
- EBREAK handling:
  - On a push with wb_inst==EBREAK_INST, ebreak_seen<=1, so no further pushes are accepted.
  - On a pop with cm_inst==EBREAK_INST, halted<=1 at the next edge; it stays 1 until reset.
  - Records queued ahead of the EBREAK still drain normally.
- Robustness:
  - wb_valid while wb_ready=0 has no effect. Upstream must hold the record; the queue does not latch it.
  - cm_ready while empty has no effect, and pointers never underflow.
- Handshake conventions: no combinational path from wb_valid to wb_ready or from cm_ready to cm_valid.

Optional Feature:
- Macro: YSYX_25060170_RETIRE_PERF_EN.
- When defined, adds two output ports:
  - perf_cycle (64): increments every cycle while halted=0.
  - perf_instret (64): increments on every pop.
- Both counters reset to 0 and freeze once halted=1.
- When not defined, neither port nor counter exists, and behaviour is otherwise identical.

Test Plan:
- Reset then single push: wb_valid=1, pc=0x80000000, inst=0x00000413, cm_ready=0 -> next cycle cm_valid=1, cm_pc=0x80000000, occupancy=1, wb_ready=1.
- Fill with cm_ready=0: push 4 records pc 0x80000000..0x8000000C -> occupancy=4, wb_ready=0. A 5th wb_valid is ignored and occupancy stays 4.
- Drain order: from the full state, hold cm_ready=1 -> pops return pc 0x80000000, 04, 08, 0C on consecutive cycles, then cm_valid=0, cm_pc=0.
- Wrap and simultaneous traffic: 10 cycles of wb_valid=1 and cm_ready=1 with occupancy held at 1 -> every record is popped exactly once in order, occupancy stays 1, and pointers wrap without loss.
- EBREAK: push inst=0x00000013, then 0x00100073, then 0x00000013 -> wb_ready=0 after the EBREAK is accepted and the third record is not queued. Draining gives halted=1 one cycle after the EBREAK pop.
- Async reset mid-fill: occupancy=3 and rst driven low between edges -> occupancy=0, cm_valid=0, halted=0 before the next clk edge.
